// File: rtl/efp_to_decimal_if.sv
// ---------------------------------------------------------------------------
// efp_to_decimal_if
//
// Handshake bundle between an EFP code producer, the decoder and the
// decimal-side consumer.
//
// Signals:
//   efp_in      [7:0]  EFP code, [7] sign, [6:0] table index
//   in_valid           efp_in valid
//   in_ready           decoder can accept a code
//   decimal_out [31:0] packed BCD result, [31:28] sign nibble
//   out_valid          decimal_out valid
//   out_ready          consumer accepts the result
//   busy               decoder is working on or holding a conversion
//
// Modports:
//   master  - the environment around the decoder (drives codes, accepts results)
//   slave   - the decoder itself
// ---------------------------------------------------------------------------
interface efp_to_decimal_if;
    logic [7:0]  efp_in;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] decimal_out;
    logic        out_valid;
    logic        out_ready;
    logic        busy;

    modport master (
        output efp_in,
        output in_valid,
        output out_ready,
        input  in_ready,
        input  decimal_out,
        input  out_valid,
        input  busy
    );

    modport slave (
        input  efp_in,
        input  in_valid,
        input  out_ready,
        output in_ready,
        output decimal_out,
        output out_valid,
        output busy
    );
endinterface

// File: rtl/efp_to_decimal.sv
// ---------------------------------------------------------------------------
// efp_to_decimal
//
// Decodes an 8-bit EFP code into a 32-bit packed-BCD decimal word. The
// magnitude is the lower bound of the code's index in the 128-entry
// logarithmic table shared with the decimal-to-EFP encoder; the sign is
// placed in the top nibble as 4'h1 for negative codes.
//
// The table is eight steps per octave anchored at lut[56] = 10000, i.e.
// lut[i] = round(10000 * 2^((i-56)/8)), stored in BCD. It is built at
// elaboration time from exact decimal mantissas so no hand-typed constants
// can drift from the encoder's values.
//
// Ports:
//   clk    in   single clock, rising edge
//   rst_n  in   asynchronous active-low reset
//   bus    slave modport of efp_to_decimal_if (code in, BCD result out,
//          valid/ready on both sides, busy status)
//
// Flow: IDLE -> LOOKUP -> FORMAT -> HOLD -> IDLE. A code is accepted only in
// IDLE; the result stays on decimal_out after it has been consumed.
//
// Optional feature macro: EFP_EXACT_ZERO_EN
//   defined   - index 0 decodes to exact zero (0x00000000) for either sign
//   undefined - index 0 decodes to lut[0] like any other index
// ---------------------------------------------------------------------------
module efp_to_decimal (
    input  logic                    clk,
    input  logic                    rst_n,
    efp_to_decimal_if.slave         bus
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        LOOKUP = 2'd1,
        FORMAT = 2'd2,
        HOLD   = 2'd3
    } state_t;

    // Table entry i as packed BCD. Mantissas 2^(k/8) are scaled by 1e12 so
    // the rounding to an integer happens once, on exact integer arithmetic.
    function automatic logic [31:0] lutValue(input int idx);
        longint unsigned mant;
        longint unsigned num;
        longint unsigned den;
        longint unsigned bin;
        logic [31:0]     bcd;
        int              k;
        int              e;
        k = idx % 8;
        e = (idx / 8) - 7;
        case (k)
            0:       mant = 64'd1000000000000;
            1:       mant = 64'd1090507732665;
            2:       mant = 64'd1189207115003;
            3:       mant = 64'd1296839554651;
            4:       mant = 64'd1414213562373;
            5:       mant = 64'd1542210825408;
            6:       mant = 64'd1681792830507;
            default: mant = 64'd1834008086409;
        endcase
        if (e >= 0) begin
            num = mant << e;
            den = 64'd100000000;
        end else begin
            num = mant;
            den = 64'd100000000 << (-e);
        end
        bin = (num + (den / 2)) / den;
        bcd = '0;
        for (int d = 0; d < 8; d++) begin
            bcd[d*4 +: 4] = 4'(bin % 64'd10);
            bin           = bin / 64'd10;
        end
        return bcd;
    endfunction

    // ROM contents; the sign nibble of every entry is zero, so only the
    // 28 magnitude bits are kept.
    logic [27:0] lutRom [128];

    for (genvar g = 0; g < 128; g++) begin : gLut
        localparam logic [31:0] ENTRY = lutValue(g);
        assign lutRom[g] = ENTRY[27:0];
    end

    state_t      state_q;
    logic        sign_q;
    logic [6:0]  idx_q;
    logic [27:0] rom_q;
    logic [31:0] decimal_q;
    logic        valid_q;

    // Whole conversion sequence: latch the code, read the ROM one cycle
    // later, format into the output register, then hold until consumed.
    // Reset discards any conversion in flight and clears the outputs at once.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= IDLE;
            sign_q    <= 1'b0;
            idx_q     <= '0;
            rom_q     <= '0;
            decimal_q <= '0;
            valid_q   <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (bus.in_valid) begin
                        sign_q  <= bus.efp_in[7];
                        idx_q   <= bus.efp_in[6:0];
                        state_q <= LOOKUP;
                    end
                end
                LOOKUP: begin
                    rom_q   <= lutRom[idx_q];
                    state_q <= FORMAT;
                end
                FORMAT: begin
`ifdef EFP_EXACT_ZERO_EN
                    // Index 0 stands for a true zero from the encoder, so
                    // the sign is dropped as well.
                    if (idx_q == 7'd0) begin
                        decimal_q <= '0;
                    end else begin
                        decimal_q <= {3'b000, sign_q, rom_q};
                    end
`else
                    decimal_q <= {3'b000, sign_q, rom_q};
`endif
                    valid_q <= 1'b1;
                    state_q <= HOLD;
                end
                HOLD: begin
                    // out_ready only matters here; decimal_q is left alone
                    // so the last result stays visible.
                    if (bus.out_ready) begin
                        valid_q <= 1'b0;
                        state_q <= IDLE;
                    end
                end
                default: begin
                    state_q <= IDLE;
                end
            endcase
        end
    end

    // Status outputs are pure decodes of the state register, so they never
    // glitch on input activity.
    assign bus.in_ready    = (state_q == IDLE);
    assign bus.busy        = (state_q != IDLE);
    assign bus.decimal_out = decimal_q;
    assign bus.out_valid   = valid_q;

endmodule

// File: tb/tb_efp_to_decimal.sv
// ---------------------------------------------------------------------------
// tb_efp_to_decimal
//
// Directed self-checking bench for efp_to_decimal. Each scenario task drives
// its own stimulus and compares outputs against hand-computed BCD values.
// Outputs are sampled 1 ns after the rising edge; inputs change there too.
// ---------------------------------------------------------------------------
module tb_efp_to_decimal;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;

    int checks   = 0;
    int failures = 0;

    efp_to_decimal_if ifc ();

    efp_to_decimal dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (ifc)
    );

    // 100 MHz free-running clock
    always #5 clk = ~clk;

    // Advance one clock and settle just past the rising edge
    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    // Present one code for a single cycle (block must be idle), then wait a
    // bounded number of edges for out_valid. edges counts the accept edge as
    // edge 1. One extra edge is run afterwards to see out_valid drop.
    task automatic applyStimulus(input logic [7:0] code, output logic [31:0] result,
                                 output int edges, output logic validAfter);
        ifc.efp_in   = code;
        ifc.in_valid = 1'b1;
        tick();
        ifc.in_valid = 1'b0;
        edges = 1;
        while (ifc.out_valid !== 1'b1 && edges < 20) begin
            tick();
            edges++;
        end
        result = ifc.decimal_out;
        tick();
        validAfter = ifc.out_valid;
    endtask

    task automatic test_reset;
        ifc.efp_in    = 8'h00;
        ifc.in_valid  = 1'b0;
        ifc.out_ready = 1'b1;
        rst_n = 1'b0;
        tick();
        tick();
        if (ifc.decimal_out !== 32'h0) begin
            failures++;
            $display("[TB] FAIL reset_decimal got=%h exp=%h", ifc.decimal_out, 32'h0);
        end
        checks++;
        if (ifc.out_valid !== 1'b0) begin
            failures++;
            $display("[TB] FAIL reset_out_valid got=%b exp=0", ifc.out_valid);
        end
        checks++;
        if (ifc.busy !== 1'b0) begin
            failures++;
            $display("[TB] FAIL reset_busy got=%b exp=0", ifc.busy);
        end
        checks++;
        rst_n = 1'b1;
        tick();
        if (ifc.in_ready !== 1'b1) begin
            failures++;
            $display("[TB] FAIL reset_in_ready got=%b exp=1", ifc.in_ready);
        end
        checks++;
    endtask

    task automatic test_basic;
        logic [31:0] result;
        int          edges;
        logic        validAfter;
        applyStimulus(8'h38, result, edges, validAfter);
        if (result !== 32'h00010000) begin
            failures++;
            $display("[TB] FAIL basic_result got=%h exp=%h", result, 32'h00010000);
        end
        checks++;
        if (edges !== 3) begin
            failures++;
            $display("[TB] FAIL basic_latency got=%0d exp=3", edges);
        end
        checks++;
        if (validAfter !== 1'b0) begin
            failures++;
            $display("[TB] FAIL basic_one_cycle_valid got=%b exp=0", validAfter);
        end
        checks++;
    endtask

    task automatic test_sign_endpoints;
        logic [7:0]  codes [4] = '{8'hB8, 8'h7F, 8'hFF, 8'h01};
        logic [31:0] exps  [4] = '{32'h10010000, 32'h04695061, 32'h14695061, 32'h00000085};
        logic [31:0] result;
        int          edges;
        logic        validAfter;
        for (int i = 0; i < 4; i++) begin
            applyStimulus(codes[i], result, edges, validAfter);
            if (result !== exps[i]) begin
                failures++;
                $display("[TB] FAIL sign_endpoint code=%h got=%h exp=%h", codes[i], result, exps[i]);
            end
            checks++;
        end
    endtask

    task automatic test_backpressure;
        int n;
        ifc.out_ready = 1'b0;
        ifc.efp_in    = 8'h40;
        ifc.in_valid  = 1'b1;
        tick();
        ifc.in_valid  = 1'b0;
        n = 1;
        while (ifc.out_valid !== 1'b1 && n < 20) begin
            tick();
            n++;
        end
        for (int c = 0; c < 10; c++) begin
            if (ifc.out_valid !== 1'b1 || ifc.decimal_out !== 32'h00020000 || ifc.in_ready !== 1'b0) begin
                failures++;
                $display("[TB] FAIL backpressure_hold cycle=%0d got valid=%b data=%h in_ready=%b exp valid=1 data=00020000 in_ready=0",
                         c, ifc.out_valid, ifc.decimal_out, ifc.in_ready);
            end
            checks++;
            tick();
        end
        ifc.out_ready = 1'b1;
        tick();
        if (ifc.out_valid !== 1'b0 || ifc.in_ready !== 1'b1) begin
            failures++;
            $display("[TB] FAIL backpressure_release got valid=%b in_ready=%b exp valid=0 in_ready=1",
                     ifc.out_valid, ifc.in_ready);
        end
        checks++;
        if (ifc.decimal_out !== 32'h00020000) begin
            failures++;
            $display("[TB] FAIL backpressure_keep_data got=%h exp=%h", ifc.decimal_out, 32'h00020000);
        end
        checks++;
    endtask

    task automatic test_busy_ignore;
        int n;
        ifc.out_ready = 1'b1;
        ifc.efp_in    = 8'h40;
        ifc.in_valid  = 1'b1;
        tick();
        // now in LOOKUP: offer a second code and keep it asserted
        ifc.efp_in    = 8'h78;
        ifc.in_valid  = 1'b1;
        if (ifc.in_ready !== 1'b0) begin
            failures++;
            $display("[TB] FAIL busy_in_ready got=%b exp=0", ifc.in_ready);
        end
        checks++;
        n = 1;
        while (ifc.out_valid !== 1'b1 && n < 20) begin
            tick();
            n++;
        end
        if (ifc.decimal_out !== 32'h00020000) begin
            failures++;
            $display("[TB] FAIL busy_first_result got=%h exp=%h", ifc.decimal_out, 32'h00020000);
        end
        checks++;
        tick();
        n = 0;
        while (ifc.busy !== 1'b1 && n < 10) begin
            tick();
            n++;
        end
        ifc.in_valid = 1'b0;
        n = 0;
        while (ifc.out_valid !== 1'b1 && n < 20) begin
            tick();
            n++;
        end
        if (ifc.decimal_out !== 32'h02560000) begin
            failures++;
            $display("[TB] FAIL busy_second_result got=%h exp=%h", ifc.decimal_out, 32'h02560000);
        end
        checks++;
        tick();
    endtask

    task automatic test_back_to_back;
        logic [31:0] r1;
        logic [31:0] r2;
        int          edges;
        logic        validAfter;
        ifc.out_ready = 1'b1;
        applyStimulus(8'h7F, r1, edges, validAfter);
        applyStimulus(8'hC0, r2, edges, validAfter);
        if (r1 !== 32'h04695061 || r2 !== 32'h10020000) begin
            failures++;
            $display("[TB] FAIL back_to_back got=%h,%h exp=04695061,10020000", r1, r2);
        end
        checks++;
    endtask

    task automatic test_reset_midop;
        int seen;
        ifc.out_ready = 1'b1;
        ifc.efp_in    = 8'h38;
        ifc.in_valid  = 1'b1;
        tick();
        ifc.in_valid  = 1'b0;
        tick();
        // block is in FORMAT; decimal_out still shows the previous result
        #2;
        rst_n = 1'b0;
        #1;
        if (ifc.out_valid !== 1'b0 || ifc.decimal_out !== 32'h0 || ifc.busy !== 1'b0) begin
            failures++;
            $display("[TB] FAIL midop_reset got valid=%b data=%h busy=%b exp valid=0 data=00000000 busy=0",
                     ifc.out_valid, ifc.decimal_out, ifc.busy);
        end
        checks++;
        tick();
        rst_n = 1'b1;
        seen = 0;
        for (int c = 0; c < 8; c++) begin
            tick();
            if (ifc.out_valid === 1'b1) seen++;
        end
        if (seen !== 0 || ifc.decimal_out !== 32'h0) begin
            failures++;
            $display("[TB] FAIL midop_no_result got valid_cycles=%0d data=%h exp valid_cycles=0 data=00000000",
                     seen, ifc.decimal_out);
        end
        checks++;
    endtask

    task automatic test_zero_code;
        logic [31:0] result;
        logic [31:0] expNeg;
        logic [31:0] expPos;
        int          edges;
        logic        validAfter;
`ifdef EFP_EXACT_ZERO_EN
        expNeg = 32'h00000000;
        expPos = 32'h00000000;
`else
        expNeg = 32'h10000078;
        expPos = 32'h00000078;
`endif
        ifc.out_ready = 1'b1;
        applyStimulus(8'h80, result, edges, validAfter);
        if (result !== expNeg) begin
            failures++;
            $display("[TB] FAIL zero_negative got=%h exp=%h", result, expNeg);
        end
        checks++;
        applyStimulus(8'h00, result, edges, validAfter);
        if (result !== expPos) begin
            failures++;
            $display("[TB] FAIL zero_positive got=%h exp=%h", result, expPos);
        end
        checks++;
    endtask

    // Main sequence
    initial begin
        test_reset();
        test_basic();
        test_sign_endpoints();
        test_backpressure();
        test_busy_ignore();
        test_back_to_back();
        test_reset_midop();
        test_zero_code();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    // Hard stop in case the sequence itself stalls
    initial begin
        #200000;
        $display("[TB] FAIL watchdog expired got=running exp=finished");
        $fatal(1, "[TB] watchdog");
    end

endmodule

// File: doc/efp_to_decimal.md
# efp_to_decimal

- Decodes an 8-bit EFP code (bit 7 = sign, bits 6:0 = magnitude index) into the 32-bit packed-BCD decimal word used on the decimal side of the EFP datapath.
- It is the inverse of the decimal-to-EFP encoder:
  - magnitude comes from the same 128-entry BCD table, `lut[0..127]`, `0x00000078`…`0x04695061`;
  - sign is returned in the top nibble as `4'h1`.
- Sits between EFP storage/compute and decimal display/host logic.
- Uses a valid/ready handshake on both sides and a small FSM with a registered ROM read.

## Interface
Parameters: none.

- `clk  in  1` — single clock; all state changes on rising edge.
- `rst_n  in  1` — reset, asynchronous, active-low.
- `efp_in  in  8` — EFP code; `[7]` sign, `[6:0]` table index.
- `in_valid  in  1` — `efp_in` valid.
- `in_ready  out  1` — block can accept a code; high only in IDLE.
- `decimal_out  out  32` — packed BCD result.
  - `[31:28]` = `4'h1` if negative, else `4'h0`.
  - `[27:0]` = magnitude digits.
- `out_valid  out  1` — `decimal_out` valid.
- `out_ready  in  1` — consumer accepts result.
- `busy  out  1` — high in any state except IDLE.

## Operation
- ROM `lut[0..127]` holds exactly the encoder's table values. Entry `i` is the lower bound of EFP index `i`.
  - Fixed entries: `lut[56]=0x00010000`, `lut[64]=0x00020000`, `lut[120]=0x02560000`.
  - All entries have `[31:28]=0`.
- FSM states: IDLE → LOOKUP → FORMAT → HOLD → IDLE.
- **IDLE:**
  - `in_ready=1`.
  - On `in_valid` (accept): latch `sign_r<=efp_in[7]`, `idx_r<=efp_in[6:0]`; go to LOOKUP.
- **LOOKUP:** `rom_q <= lut[idx_r]`; go to FORMAT.
- **FORMAT:**
  - `decimal_out <= {3'b000, sign_r, rom_q[27:0]}`.
  - `out_valid <= 1`; go to HOLD.
- **HOLD:**
  - `decimal_out` and `out_valid` held stable.
  - On `out_ready`: `out_valid <= 0`; go to IDLE.
- No input is accepted while `busy=1`. A new `in_valid` is ignored until IDLE; the upstream must hold it.
- `decimal_out` keeps its last value after handshake completion, until the next FORMAT.
- The block does no rounding; the result is the table lower bound of the index.

## Timing
- Reset (`rst_n=0`, asynchronous):
  - state=IDLE;
  - `decimal_out=0x00000000`, `out_valid=0`, `busy=0`;
  - `in_ready=1` after reset deasserts;
  - `sign_r`, `idx_r`, `rom_q` cleared.
- Reset mid-operation: conversion discarded immediately, no `out_valid` pulse; outputs go to reset values asynchronously.
- Latency:
  - accept at edge T;
  - `out_valid` high after edge T+3;
  - result consumed at first edge with `out_valid&&out_ready`.
- Best-case throughput: one code per 4 cycles (`out_ready` tied high).
- `out_ready` high in FORMAT has no effect. It is sampled only in HOLD.
- `in_ready` is combinational from state (`state==IDLE`). `out_valid` and `busy` are registered/state-decoded, glitch-free.

## Configuration
- Macro: `EFP_EXACT_ZERO_EN`.
- **Defined:** when `efp_in[6:0]==0`, FORMAT outputs `0x00000000` regardless of sign, so `0x00` and `0x80` both decode to exact zero. This matches the encoder mapping zero input to code 0.
- **Undefined:**
  - index 0 decodes to `lut[0]` like every other index: `0x00` → `0x00000078`, `0x80` → `0x10000078`.
  - The ROM path is used unconditionally.

## Test plan
- Reset then `efp_in=0x38` with `in_valid` one cycle, `out_ready=1` → `decimal_out=0x00010000`, `out_valid` high exactly one cycle, 3 edges after accept.
- Sign and endpoints:
  - `0xB8` → `0x10010000`;
  - `0x7F` → `0x04695061`;
  - `0xFF` → `0x14695061`;
  - `0x01` → `0x00000085`.
- Backpressure:
  - `efp_in=0x40`, `out_ready=0` for 10 cycles → `out_valid` and `0x00020000` stable, `in_ready=0`;
  - then `out_ready=1` → `out_valid` drops next edge, `in_ready=1`.
- Input ignored while busy: assert `in_valid` with `0x78` during LOOKUP of `0x40` → first result `0x00020000`; `0x78` is accepted only after return to IDLE, giving `0x02560000`.
- Reset mid-op: drop `rst_n` in FORMAT → `out_valid=0` and `decimal_out=0` immediately; no result after release.
- Zero code: `0x80`
  - with `EFP_EXACT_ZERO_EN` → `0x00000000`;
  - without → `0x10000078`.
